// File: rtl/op1_feeder.sv
// Loads 16 activation bytes plus a sign-weight vector into op1's operand pairs, then collects its sum.
// Optional build macro OP1_FEEDER_INV_CORRECT_EN adds popcount(inv) to the sampled sum.
module op1_feeder #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] w_in,
    output logic [7:0]  data0_out,
    output logic [7:0]  data1_out,
    output logic [7:0]  data2_out,
    output logic [7:0]  data3_out,
    output logic [7:0]  data4_out,
    output logic [7:0]  data5_out,
    output logic [7:0]  data6_out,
    output logic [7:0]  data7_out,
    output logic [7:0]  data8_out,
    output logic [7:0]  data9_out,
    output logic [7:0]  data10_out,
    output logic [7:0]  data11_out,
    output logic [7:0]  data12_out,
    output logic [7:0]  data13_out,
    output logic [7:0]  data14_out,
    output logic [7:0]  data15_out,
    output logic        inv0_out,
    output logic        inv1_out,
    output logic        inv2_out,
    output logic        inv3_out,
    output logic        inv4_out,
    output logic        inv5_out,
    output logic        inv6_out,
    output logic        inv7_out,
    output logic        inv8_out,
    output logic        inv9_out,
    output logic        inv10_out,
    output logic        inv11_out,
    output logic        inv12_out,
    output logic        inv13_out,
    output logic        inv14_out,
    output logic        inv15_out,
    input  logic [11:0] sum_in,
    output logic [11:0] r_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic        busy
);

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_OUT} state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [2:0]  cnt;
    logic        armed;
    logic [7:0]  data_q [16];
    logic [15:0] inv_q;
    logic [11:0] result;
    logic        s_fire;
    logic        wait_done;

    always_comb begin
        state_nx  = state;
        s_ready   = 1'b0;
        r_valid   = 1'b0;
        busy      = 1'b0;
        wait_done = 1'b0;
        case (state)
            S_LOAD: begin
                // armed keeps s_ready low until the first edge after reset release
                s_ready = armed;
                if (s_valid && armed && idx == 4'd15) state_nx = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                wait_done = (cnt == LAT_C);
                if (wait_done) state_nx = S_OUT;
            end
            S_OUT: begin
                busy    = 1'b1;
                r_valid = 1'b1;
                if (r_ready) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    assign s_fire = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_LOAD;
            idx    <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
            inv_q  <= '0;
            r_data <= '0;
            for (int unsigned i = 0; i < 16; i++) data_q[i] <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (s_fire) begin
                data_q[idx] <= s_data;
                idx         <= idx + 4'd1;
                if (idx == 4'd0) inv_q <= w_in;
            end
            if (state == S_WAIT) begin
                cnt <= wait_done ? '0 : cnt + 3'd1;
                if (wait_done) r_data <= result;
            end
        end
    end

`ifdef OP1_FEEDER_INV_CORRECT_EN
    logic [4:0] inv_cnt;
    always_comb begin
        inv_cnt = '0;
        for (int unsigned i = 0; i < 16; i++) inv_cnt = inv_cnt + 5'(inv_q[i]);
    end
    // op1 contributes -d-1 per inverted element; adding the count restores exact -d
    assign result = sum_in + 12'(inv_cnt);
`else
    assign result = sum_in;
`endif

    assign data0_out  = data_q[0];
    assign data1_out  = data_q[1];
    assign data2_out  = data_q[2];
    assign data3_out  = data_q[3];
    assign data4_out  = data_q[4];
    assign data5_out  = data_q[5];
    assign data6_out  = data_q[6];
    assign data7_out  = data_q[7];
    assign data8_out  = data_q[8];
    assign data9_out  = data_q[9];
    assign data10_out = data_q[10];
    assign data11_out = data_q[11];
    assign data12_out = data_q[12];
    assign data13_out = data_q[13];
    assign data14_out = data_q[14];
    assign data15_out = data_q[15];

    assign inv0_out  = inv_q[0];
    assign inv1_out  = inv_q[1];
    assign inv2_out  = inv_q[2];
    assign inv3_out  = inv_q[3];
    assign inv4_out  = inv_q[4];
    assign inv5_out  = inv_q[5];
    assign inv6_out  = inv_q[6];
    assign inv7_out  = inv_q[7];
    assign inv8_out  = inv_q[8];
    assign inv9_out  = inv_q[9];
    assign inv10_out = inv_q[10];
    assign inv11_out = inv_q[11];
    assign inv12_out = inv_q[12];
    assign inv13_out = inv_q[13];
    assign inv14_out = inv_q[14];
    assign inv15_out = inv_q[15];

endmodule

// File: tb/tb_op1_feeder.sv
// Self-checking bench for op1_feeder: LAT=1 instance for most vectors, LAT=0 instance for latency.
// op1 is modelled as a combinational sum of the operand outputs.
module tb_op1_feeder;

    typedef struct packed {
        logic [15:0][7:0] d;
        logic [15:0]      w;
        logic             bub;
        logic [2:0]       hold;
        logic [11:0]      exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [7:0]       s_data;
    logic             sv, use0, r_ready;
    logic             s_valid1, s_valid0, s_ready1, s_ready0;
    logic [15:0]      w_in;
    logic [15:0][7:0] dv1, dv0, dv_m;
    logic [15:0]      iv1, iv0, iv_m;
    logic [11:0]      sum1, sum0, rd1, rd0, rd_m;
    logic             rv1, rv0, busy1, busy0;
    logic             s_ready_m, rv_m, busy_m;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] op1(input logic [15:0][7:0] d, input logic [15:0] inv);
        logic [11:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) s = s + (inv[i] ? ~{4'h0, d[i]} : {4'h0, d[i]});
        return s;
    endfunction

    // Reference result: signed sum of +-d with the -1 bias per inverted element unless corrected
    function automatic logic [11:0] ref_sum(input logic [15:0][7:0] d, input logic [15:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += w[i] ? (-int'(d[i]) - 1) : int'(d[i]);
`ifdef OP1_FEEDER_INV_CORRECT_EN
        s += $countones(w);
`endif
        return 12'(s);
    endfunction

    assign sum1      = op1(dv1, iv1);
    assign sum0      = op1(dv0, iv0);
    assign s_valid1  = sv & ~use0;
    assign s_valid0  = sv & use0;
    assign s_ready_m = use0 ? s_ready0 : s_ready1;
    assign rv_m      = use0 ? rv0 : rv1;
    assign rd_m      = use0 ? rd0 : rd1;
    assign busy_m    = use0 ? busy0 : busy1;
    assign dv_m      = use0 ? dv0 : dv1;
    assign iv_m      = use0 ? iv0 : iv1;

    op1_feeder #(.LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid1), .s_ready(s_ready1), .w_in(w_in),
        .data0_out(dv1[0]), .data1_out(dv1[1]), .data2_out(dv1[2]), .data3_out(dv1[3]),
        .data4_out(dv1[4]), .data5_out(dv1[5]), .data6_out(dv1[6]), .data7_out(dv1[7]),
        .data8_out(dv1[8]), .data9_out(dv1[9]), .data10_out(dv1[10]), .data11_out(dv1[11]),
        .data12_out(dv1[12]), .data13_out(dv1[13]), .data14_out(dv1[14]), .data15_out(dv1[15]),
        .inv0_out(iv1[0]), .inv1_out(iv1[1]), .inv2_out(iv1[2]), .inv3_out(iv1[3]),
        .inv4_out(iv1[4]), .inv5_out(iv1[5]), .inv6_out(iv1[6]), .inv7_out(iv1[7]),
        .inv8_out(iv1[8]), .inv9_out(iv1[9]), .inv10_out(iv1[10]), .inv11_out(iv1[11]),
        .inv12_out(iv1[12]), .inv13_out(iv1[13]), .inv14_out(iv1[14]), .inv15_out(iv1[15]),
        .sum_in(sum1), .r_data(rd1), .r_valid(rv1), .r_ready(r_ready), .busy(busy1)
    );

    op1_feeder #(.LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid0), .s_ready(s_ready0), .w_in(w_in),
        .data0_out(dv0[0]), .data1_out(dv0[1]), .data2_out(dv0[2]), .data3_out(dv0[3]),
        .data4_out(dv0[4]), .data5_out(dv0[5]), .data6_out(dv0[6]), .data7_out(dv0[7]),
        .data8_out(dv0[8]), .data9_out(dv0[9]), .data10_out(dv0[10]), .data11_out(dv0[11]),
        .data12_out(dv0[12]), .data13_out(dv0[13]), .data14_out(dv0[14]), .data15_out(dv0[15]),
        .inv0_out(iv0[0]), .inv1_out(iv0[1]), .inv2_out(iv0[2]), .inv3_out(iv0[3]),
        .inv4_out(iv0[4]), .inv5_out(iv0[5]), .inv6_out(iv0[6]), .inv7_out(iv0[7]),
        .inv8_out(iv0[8]), .inv9_out(iv0[9]), .inv10_out(iv0[10]), .inv11_out(iv0[11]),
        .inv12_out(iv0[12]), .inv13_out(iv0[13]), .inv14_out(iv0[14]), .inv15_out(iv0[15]),
        .sum_in(sum0), .r_data(rd0), .r_valid(rv0), .r_ready(r_ready), .busy(busy0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sends the first n bytes of v; t_last is the cycle of the 16th accept (or -1)
    task automatic send_vec(input vec_t v, input int n, output int t_last);
        int  k;
        int  guard;
        bit  x;
        k      = 0;
        guard  = 0;
        t_last = -1;
        while (k < n && guard < 400) begin
            sv     = v.bub ? ((guard % 2) == 0) : 1'b1;
            s_data = sv ? v.d[k] : 8'($urandom);
            w_in   = (k == 0) ? v.w : 16'($urandom);
            x      = sv && s_ready_m;
            @(posedge clk);
            #1;
            if (x) begin
                chk("load_byte", dv_m[k], v.d[k]);
                if (k == 15) t_last = cyc - 1;
                k++;
            end
            guard++;
        end
        sv = 1'b0;
        chk("load_timeout", 128'(k), 128'(n));
    endtask

    task automatic get_result(input vec_t v, input int t_last, input int lat);
        int          guard;
        logic [11:0] held;
        guard   = 0;
        r_ready = 1'b0;
        sv      = 1'b1;
        while (!rv_m && guard < 30) begin
            s_data = 8'($urandom);
            chk("wait_sready", s_ready_m, 1'b0);
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rvalid_timeout", rv_m, 1'b1);
        chk("latency", 128'(cyc - t_last), 128'(lat + 2));
        chk("r_data", rd_m, v.exp);
        chk("operands", dv_m, v.d);
        chk("invs", iv_m, v.w);
        held = rd_m;
        for (int h = 0; h < int'(v.hold); h++) begin
            @(posedge clk);
            #1;
            chk("bp_rdata", rd_m, held);
            chk("bp_sready", s_ready_m, 1'b0);
            chk("bp_busy", busy_m, 1'b1);
            chk("bp_rvalid", rv_m, 1'b1);
        end
        sv      = 1'b0;
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        chk("restart_sready", s_ready_m, 1'b1);
        chk("rvalid_drop", rv_m, 1'b0);
        chk("busy_drop", busy_m, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[10];
    vec_t vr;
    int   t_last;

    initial begin
        vecs[0].w = 16'h0000; vecs[0].bub = 1'b0; vecs[0].hold = 3'd0; vecs[0].exp = 12'h078;
        vecs[1].w = 16'hFFFF; vecs[1].bub = 1'b0; vecs[1].hold = 3'd5;
`ifdef OP1_FEEDER_INV_CORRECT_EN
        vecs[1].exp = 12'hFF0;
`else
        vecs[1].exp = 12'hFE0;
`endif
        vecs[2].w = 16'h0000; vecs[2].bub = 1'b1; vecs[2].hold = 3'd2; vecs[2].exp = 12'h078;
        for (int i = 0; i < 16; i++) begin
            vecs[0].d[i] = 8'(i);
            vecs[1].d[i] = 8'h01;
            vecs[2].d[i] = 8'(i);
        end
        for (int j = 3; j < 10; j++) begin
            for (int i = 0; i < 16; i++) vecs[j].d[i] = 8'($urandom);
            vecs[j].w    = 16'($urandom);
            vecs[j].bub  = 1'($urandom);
            vecs[j].hold = 3'($urandom_range(0, 4));
            vecs[j].exp  = ref_sum(vecs[j].d, vecs[j].w);
        end

        // reset with s_valid high
        rst_n = 1'b0; sv = 1'b1; use0 = 1'b0; r_ready = 1'b0; s_data = 8'hA5; w_in = 16'hFFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_sready", s_ready_m, 1'b0);
        end
        chk("rst_data", dv1, '0);
        chk("rst_inv", iv1, '0);
        chk("rst_rdata", rd1, '0);
        chk("rst_rvalid", rv1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_data_lat0", dv0, '0);
        rst_n = 1'b1;
        sv    = 1'b0;
        @(posedge clk);
        #1;
        chk("release_sready", s_ready_m, 1'b1);
        chk("release_busy", busy_m, 1'b0);

        for (int j = 0; j < 10; j++) begin
            send_vec(vecs[j], 16, t_last);
            get_result(vecs[j], t_last, 1);
        end

        // LAT = 0 instance
        use0 = 1'b1;
        send_vec(vecs[0], 16, t_last);
        get_result(vecs[0], t_last, 0);
        use0 = 1'b0;

        // reset mid-load after 7 bytes
        for (int i = 0; i < 16; i++) vr.d[i] = 8'($urandom);
        vr.w = 16'($urandom); vr.bub = 1'b0; vr.hold = 3'd1;
        send_vec(vr, 7, t_last);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", dv1, '0);
        chk("midrst_inv", iv1, '0);
        for (int i = 0; i < 16; i++) vr.d[i] = 8'($urandom);
        vr.w   = ~vr.w;
        vr.exp = ref_sum(vr.d, vr.w);
        send_vec(vr, 16, t_last);
        get_result(vr, t_last, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
